// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : 2-read / 2-write register file with bypass, zero register and
//              a per-register load-pending scoreboard.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1
) (
   input  logic                  Clock_i,
   input  logic                  Reset_i,
   input  logic [ADDR_WIDTH-1:0] ReadAddr1_i,
   input  logic [ADDR_WIDTH-1:0] ReadAddr2_i,
   output logic [DATA_WIDTH-1:0] ReadData1_o,
   output logic [DATA_WIDTH-1:0] ReadData2_o,
   output logic                  ReadBusy1_o,
   output logic                  ReadBusy2_o,
   input  logic                  RegWriteA_i,
   input  logic [ADDR_WIDTH-1:0] WriteAddrA_i,
   input  logic [DATA_WIDTH-1:0] WriteDataA_i,
   input  logic                  RegWriteB_i,
   input  logic [ADDR_WIDTH-1:0] WriteAddrB_i,
   input  logic [DATA_WIDTH-1:0] WriteDataB_i,
   input  logic                  Reserve_i,
   input  logic [ADDR_WIDTH-1:0] ReserveAddr_i,
   output logic [ADDR_WIDTH:0]   BusyCount_o
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_d;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic [ADDR_WIDTH:0]   cnt_d;

   logic w_wr_a;
   logic w_wr_b;
   logic w_rsv;

   // Anything aimed at register 0 is discarded up front.
   assign w_wr_a = RegWriteA_i && (WriteAddrA_i != '0);
   assign w_wr_b = RegWriteB_i && (WriteAddrB_i != '0);
   assign w_rsv  = Reserve_i   && (ReserveAddr_i != '0);

   // Port B is applied last so it wins an address collision with port A.
   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (w_wr_a) begin
            regs_q[WriteAddrA_i] <= WriteDataA_i;
         end
         if (w_wr_b) begin
            regs_q[WriteAddrB_i] <= WriteDataB_i;
         end
      end
   end

   // A reserve in the same cycle as the load's return keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (w_wr_b) begin
         busy_d[WriteAddrB_i] = 1'b0;
      end
      if (w_rsv) begin
         busy_d[ReserveAddr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] data;
      if (Reset_i || (addr == '0)) begin
         data = '0;
      end else if ((BYPASS != 0) && w_wr_b && (WriteAddrB_i == addr)) begin
         data = WriteDataB_i;
      end else if ((BYPASS != 0) && w_wr_a && (WriteAddrA_i == addr)) begin
         data = WriteDataA_i;
      end else begin
         data = regs_q[addr];
      end
      return data;
   endfunction

   // A returning load hides the busy flag only when it is forwarded and not re-reserved.
   function automatic logic f_busy(input logic [ADDR_WIDTH-1:0] addr);
      logic busy;
      logic fwd;
      fwd  = (BYPASS != 0) && w_wr_b && (WriteAddrB_i == addr) &&
             !(w_rsv && (ReserveAddr_i == addr));
      busy = !Reset_i && (addr != '0) && busy_q[addr] && !fwd;
      return busy;
   endfunction

   assign ReadData1_o = f_read(ReadAddr1_i);
   assign ReadData2_o = f_read(ReadAddr2_i);
   assign ReadBusy1_o = f_busy(ReadAddr1_i);
   assign ReadBusy2_o = f_busy(ReadAddr2_i);
   assign BusyCount_o = cnt_q;

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the single-write MIPS register file. Provides 2 asynchronous read ports and 2 write ports: port A for ALU writeback and port B for load writeback. Adds same-cycle write-to-read bypass, a hardwired zero register, and a per-register pending scoreboard for load-use hazard detection. Sits in the decode stage and feeds the hazard unit with ReadBusy flags.

Parameters:
DATA_WIDTH, 32, register width in bits.
ADDR_WIDTH, 5, address width; NUM_REGS = 2**ADDR_WIDTH.
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
ReadAddr1  in  ADDR_WIDTH  read port 1 address
ReadAddr2  in  ADDR_WIDTH  read port 2 address
ReadData1  out  DATA_WIDTH  read port 1 data (combinational)
ReadData2  out  DATA_WIDTH  read port 2 data (combinational)
ReadBusy1  out  1  addressed register has an outstanding load
ReadBusy2  out  1  addressed register has an outstanding load
RegWriteA  in  1  port A write enable
WriteAddrA  in  ADDR_WIDTH  port A address
WriteDataA  in  DATA_WIDTH  port A data
RegWriteB  in  1  port B (load) write enable
WriteAddrB  in  ADDR_WIDTH  port B address
WriteDataB  in  DATA_WIDTH  port B data
Reserve  in  1  load issued: mark ReserveAddr pending
ReserveAddr  in  ADDR_WIDTH  destination register of the issued load
BusyCount  out  ADDR_WIDTH+1  number of pending registers (registered)

Behaviour:
- Reset, asynchronous and active-high:
  - All registers clear to 0.
  - All busy bits clear to 0.
  - BusyCount clears to 0.
  - ReadData* read 0 and ReadBusy* read 0 while Reset is high.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored on both ports.
  - Reserve to address 0 is ignored.
  - It is never busy and never bypassed.
- Writes:
  - Committed on the rising edge of Clock when the enable is high and the address is non-zero.
  - Both ports writing the same address in the same cycle: port B wins.
  - Different addresses: both writes commit.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1, a read address matching an active non-zero write returns that write's data in the same cycle; B has priority over A.
  - With BYPASS=0, reads return the array contents; a write becomes visible in the cycle after the edge.
- Scoreboard:
  - Reserve sets busy[ReserveAddr] at the clock edge.
  - A port B write clears busy[WriteAddrB] at the clock edge.
  - A port A write never changes busy bits.
  - Reserve and a port B write to the same address in the same cycle: busy stays 1 (the new load is outstanding).
  - Reserve to an already-busy register: stays busy, BusyCount unchanged.
  - A port B write to a non-busy register: no scoreboard change.
- ReadBusyN:
  - Equals busy[ReadAddrN].
  - With BYPASS=1, it is forced to 0 when port B is writing ReadAddrN in this cycle and Reserve is not targeting the same address, because the data is forwarded.
  - It is 0 for address 0.
- BusyCount:
  - Registered; always equals the population count of the busy bits after each edge.
  - Net change per cycle is in {-1, 0, +1}.
  - Maximum value is NUM_REGS-1.

Test Plan:
- Reset mid-operation: write R5=0xDEADBEEF, Reserve R7, then pulse Reset between edges -> ReadData(R5)=0 and ReadBusy(R7)=0 immediately; BusyCount=0.
- Port A writes R3=0x12345678; ReadAddr1=3 in the same cycle -> BYPASS=1: ReadData1=0x12345678 that cycle. BYPASS=0: old value that cycle, new value the next cycle.
- Write conflict: A writes R4=0x1111 and B writes R4=0x2222 in the same cycle -> ReadData(R4)=0x2222 (bypass and after the edge).
- Zero register: both ports write R0=0xFFFFFFFF and Reserve R0 -> ReadData(R0)=0, ReadBusy=0, BusyCount unchanged.
- Scoreboard:
  - Reserve R9 -> next cycle ReadBusy=1, BusyCount=1.
  - Port A write to R9 -> still busy.
  - Port B write R9=0xABCD -> ReadBusy=0 that cycle (BYPASS=1), BusyCount=0 after the edge.
- Simultaneous Reserve R9 and B write R9 -> R9 holds new data; ReadBusy stays 1; BusyCount unchanged. Reserve all 31 non-zero registers -> BusyCount=31.
